// File: rtl/alsu_req_scheduler.sv
// alsu_req_scheduler: shares one 2-cycle-latency ALSU between two requesters.
// The ALSU sees each command for exactly one cycle. Between commands it is parked
// on an idle pattern, so shift/rotate ops always start from out = 0.
//
// state   | meaning
// S_IDLE  | ALSU parked on idle pattern; grant once a request is pending and the gap is met
// S_ISSUE | accepted command driven on alsu_ctl for this single cycle
// S_WAIT  | idle pattern back on alsu_ctl while the ALSU computes
// S_CAPT  | ALSU result valid on alsu_out; capture it into the response registers
// S_RESP  | response offered, held stable until rsp_ready
module alsu_req_scheduler #(
  parameter string       ARB_MODE = "RR",
  parameter int unsigned MIN_GAP  = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [15:0] req_cmd0,
  input  logic [15:0] req_cmd1,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [5:0]  rsp_data,
  output logic        rsp_err,
  output logic [15:0] alsu_ctl,
  input  logic [5:0]  alsu_out,
  output logic        busy
);

  // Command packing:
  // {direction,serial_in,bypass_B,bypass_A,red_op_B,red_op_A,cin,opcode[2:0],B[2:0],A[2:0]}
  // bypass_A=1 with A=0 forces ALSU out to 0.
  localparam logic [15:0]   IDLE_PAT  = 16'h1000;
  localparam bit            FIXED_PRI = (ARB_MODE == "FIXED0");
  localparam int            GW        = $clog2(MIN_GAP + 1);
  localparam logic [GW-1:0] GAP_MAX   = GW'(MIN_GAP);
  // The accept cycle itself is an idle-pattern cycle, so one fewer is needed beforehand.
  localparam logic [GW-1:0] GAP_OK    = GW'(MIN_GAP - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_CAPT  = 3'd3,
    S_RESP  = 3'd4
  } state_t;

  state_t        state, state_nxt;
  logic [GW-1:0] gap_cnt;
  logic          rr_last;
  logic          grant_id;
  logic          grant_en;
  logic [15:0]   grant_cmd;
  logic          gid_q;
  logic          err_q;

  // Invalid command that the ALSU will not bypass: reduction on arithmetic/shift ops, or op 6/7.
  function automatic logic cmd_err(input logic [15:0] c);
    logic [2:0] op;
    op = c[8:6];
    return ~c[12] & ~c[13] & (((c[10] | c[11]) & (op[1] | op[2])) | (op[1] & op[2]));
  endfunction

  // Arbitration choice among the currently valid requesters.
  always_comb begin
    grant_id = 1'b0;
    unique case (req_valid)
      2'b10:   grant_id = 1'b1;
      2'b11:   grant_id = FIXED_PRI ? 1'b0 : ~rr_last;
      default: grant_id = 1'b0;
    endcase
    grant_cmd = grant_id ? req_cmd1 : req_cmd0;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic and the combinational accept strobe.
  always_comb begin
    state_nxt = state;
    req_ready = 2'b00;
    grant_en  = 1'b0;
    unique case (state)
      S_IDLE: begin
        if ((|req_valid) && (gap_cnt >= GAP_OK)) begin
          grant_en  = 1'b1;
          req_ready = grant_id ? 2'b10 : 2'b01;
          state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: state_nxt = S_WAIT;
      S_WAIT:  state_nxt = S_CAPT;
      S_CAPT:  state_nxt = S_RESP;
      S_RESP:  if (rsp_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Command latch, ALSU drive, result capture and response handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alsu_ctl  <= IDLE_PAT;
      gid_q     <= 1'b0;
      err_q     <= 1'b0;
      rr_last   <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
    end else begin
      if (grant_en) begin
        alsu_ctl <= grant_cmd;
        gid_q    <= grant_id;
        err_q    <= cmd_err(grant_cmd);
        rr_last  <= grant_id;
      end
      if (state == S_ISSUE) alsu_ctl <= IDLE_PAT;
      if (state == S_CAPT) begin
        rsp_data  <= alsu_out;
        rsp_id    <= gid_q;
        rsp_err   <= err_q;
        rsp_valid <= 1'b1;
      end
      if ((state == S_RESP) && rsp_ready) rsp_valid <= 1'b0;
    end
  end

  // Count idle-pattern cycles on the ALSU inputs; restart whenever a command is issued.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                         gap_cnt <= '0;
    else if (state == S_ISSUE)                          gap_cnt <= '0;
    else if ((alsu_ctl == IDLE_PAT) && (gap_cnt < GAP_MAX)) gap_cnt <= gap_cnt + 1'b1;
  end

  assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_alsu_req_scheduler.sv
// tb_alsu_req_scheduler: one round-robin and one fixed-priority scheduler, each driving
// its own behavioural ALSU; a monitor checks every cycle against a transaction-level model.
module tb_alsu_req_scheduler;

  localparam logic [15:0] IDLE_PAT = 16'h1000;

  logic        clk = 1'b0;
  logic        rst_n     [2];
  logic [1:0]  req_valid [2];
  logic [1:0]  req_ready [2];
  logic [15:0] cmd0      [2];
  logic [15:0] cmd1      [2];
  logic        rsp_valid [2];
  logic        rsp_ready [2];
  logic        rsp_id    [2];
  logic [5:0]  rsp_data  [2];
  logic        rsp_err   [2];
  logic [15:0] alsu_ctl  [2];
  logic [5:0]  alsu_out  [2] = '{6'd0, 6'd0};
  logic [15:0] alsu_in_q [2] = '{16'h1000, 16'h1000};
  logic        busy      [2];

  int n_chk = 0;
  int n_err = 0;

  // Transaction-level model state per instance.
  bit          exp_v     [2];
  logic [15:0] exp_cmd   [2];
  bit          exp_id    [2];
  int          acc_cyc   [2];
  int          since_rst [2];
  int          n_hs      [2];
  bit          last_g    [2];
  logic [7:0]  id_hist   [2];
  logic [5:0]  last_data [2];
  bit          prev_rv   [2];
  bit          prev_rr   [2];
  logic [7:0]  prev_b    [2];
  int          cyc = 0;

  always #5 clk = ~clk;

  alsu_req_scheduler #(.ARB_MODE("RR"), .MIN_GAP(2)) u_rr (
    .clk(clk), .rst_n(rst_n[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_cmd0(cmd0[0]), .req_cmd1(cmd1[0]), .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
    .rsp_id(rsp_id[0]), .rsp_data(rsp_data[0]), .rsp_err(rsp_err[0]),
    .alsu_ctl(alsu_ctl[0]), .alsu_out(alsu_out[0]), .busy(busy[0]));

  alsu_req_scheduler #(.ARB_MODE("FIXED0"), .MIN_GAP(2)) u_fx (
    .clk(clk), .rst_n(rst_n[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_cmd0(cmd0[1]), .req_cmd1(cmd1[1]), .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
    .rsp_id(rsp_id[1]), .rsp_data(rsp_data[1]), .rsp_err(rsp_err[1]),
    .alsu_ctl(alsu_ctl[1]), .alsu_out(alsu_out[1]), .busy(busy[1]));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] mk(input bit dir, input bit sin, input bit byb, input bit bya,
                                     input bit redb, input bit reda, input bit cin,
                                     input logic [2:0] op, input logic [2:0] b, input logic [2:0] a);
    return {dir, sin, byb, bya, redb, reda, cin, op, b, a};
  endfunction

  function automatic bit ref_err(input logic [15:0] c);
    int op;
    op = int'(c[8:6]);
    if (c[12] || c[13]) return 1'b0;
    return (op >= 6) || ((c[10] || c[11]) && (op >= 2));
  endfunction

  // ALSU behaviour: prev is the ALSU's current out, used by shift/rotate.
  function automatic logic [5:0] alsu_f(input logic [15:0] c, input logic [5:0] prev);
    logic [2:0] av, bv;
    int a, b, op;
    av = c[2:0];
    bv = c[5:3];
    a  = int'($signed(av));
    b  = int'($signed(bv));
    op = int'(c[8:6]);
    if (c[12]) return 6'(a);
    if (c[13]) return 6'(b);
    if (ref_err(c)) return 6'd0;
    case (op)
      0: if (c[10]) return {5'd0, &av}; else if (c[11]) return {5'd0, &bv}; else return 6'(a & b);
      1: if (c[10]) return {5'd0, ^av}; else if (c[11]) return {5'd0, ^bv}; else return 6'(a ^ b);
      2: return 6'(a + b + int'(c[9]));
      3: return 6'(a * b);
      4: return c[15] ? {prev[4:0], c[14]} : {c[14], prev[5:1]};
      5: return c[15] ? {prev[4:0], prev[5]} : {prev[0], prev[5:1]};
      default: return 6'd0;
    endcase
  endfunction

  // Behavioural ALSU per instance: input register then output register (2-cycle latency).
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      alsu_in_q[k] <= alsu_ctl[k];
      alsu_out[k]  <= alsu_f(alsu_in_q[k], alsu_out[k]);
    end
  end

  // Per-cycle monitor: grant rules, ALSU drive, response timing, contents and hold.
  always @(negedge clk) begin
    bit g, expg, fr;
    logic [15:0] ectl;
    for (int k = 0; k < 2; k++) begin
      if (!rst_n[k]) begin
        chk("rst_busy", 32'(busy[k]), 32'd0);
        chk("rst_rspv", 32'(rsp_valid[k]), 32'd0);
        chk("rst_ready", 32'(req_ready[k]), 32'd0);
        chk("rst_ctl", 32'(alsu_ctl[k]), 32'(IDLE_PAT));
        exp_v[k] = 1'b0; since_rst[k] = 0; prev_rv[k] = 1'b0; last_g[k] = 1'b1;
        acc_cyc[k] = -100;
      end else begin
        fr = !exp_v[k] && (since_rst[k] >= 1);
        chk("rdy_mask", 32'(req_ready[k] & ~req_valid[k]), 32'd0);
        chk("rdy_both", 32'(req_ready[k] == 2'b11), 32'd0);
        chk("grant_when", 32'(|req_ready[k]), 32'(fr && (|req_valid[k])));
        if (|req_ready[k]) begin
          g = req_ready[k][1];
          if (req_valid[k] == 2'b11) expg = (k == 1) ? 1'b0 : !last_g[k];
          else                       expg = req_valid[k][1];
          chk("arb", 32'(g), 32'(expg));
          last_g[k]  = g;
          exp_v[k]   = 1'b1;
          exp_cmd[k] = g ? cmd1[k] : cmd0[k];
          exp_id[k]  = g;
          acc_cyc[k] = cyc;
        end
        ectl = (exp_v[k] && (cyc == acc_cyc[k] + 1)) ? exp_cmd[k] : IDLE_PAT;
        chk("ctl", 32'(alsu_ctl[k]), 32'(ectl));
        chk("busy", 32'(busy[k]), 32'(exp_v[k] && (cyc > acc_cyc[k])));
        chk("rspv", 32'(rsp_valid[k]), 32'(exp_v[k] && (cyc >= acc_cyc[k] + 4)));
        if (rsp_valid[k] && !prev_rv[k]) begin
          chk("rsp_id", 32'(rsp_id[k]), 32'(exp_id[k]));
          chk("rsp_data", 32'(rsp_data[k]), 32'(alsu_f(exp_cmd[k], 6'd0)));
          chk("rsp_err", 32'(rsp_err[k]), 32'(ref_err(exp_cmd[k])));
        end
        if (rsp_valid[k] && prev_rv[k] && !prev_rr[k])
          chk("rsp_hold", 32'({rsp_id[k], rsp_err[k], rsp_data[k]}), 32'(prev_b[k]));
        if (rsp_valid[k] && rsp_ready[k]) begin
          exp_v[k]     = 1'b0;
          n_hs[k]      = n_hs[k] + 1;
          id_hist[k]   = {id_hist[k][6:0], rsp_id[k]};
          last_data[k] = rsp_data[k];
        end
        prev_rv[k]   = rsp_valid[k];
        prev_rr[k]   = rsp_ready[k];
        prev_b[k]    = {rsp_id[k], rsp_err[k], rsp_data[k]};
        since_rst[k] = since_rst[k] + 1;
      end
    end
    cyc++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one command on requester r, optionally raising the other requester once accepted,
  // hold rsp_ready low for 'hold' response cycles, and return the handshaken response.
  task automatic do_cmd(input int k, input int r, input logic [15:0] c, input int hold,
                        input bit bg, output logic [5:0] d, output bit e, output bit id);
    int t;
    if (r == 0) cmd0[k] = c; else cmd1[k] = c;
    req_valid[k][r] = 1'b1;
    rsp_ready[k]    = (hold == 0);
    t = 0;
    do begin @(negedge clk); t++; end while (!req_ready[k][r] && t < 50);
    chk("acc_timeout", 32'(req_ready[k][r]), 32'd1);
    step();
    req_valid[k][r] = 1'b0;
    if (bg) req_valid[k][1-r] = 1'b1;
    t = 0;
    do begin @(negedge clk); t++; end while (!rsp_valid[k] && t < 50);
    chk("rsp_timeout", 32'(rsp_valid[k]), 32'd1);
    if (hold > 0) begin
      repeat (hold) step();
      rsp_ready[k] = 1'b1;
      @(negedge clk);
    end
    d  = rsp_data[k];
    e  = rsp_err[k];
    id = rsp_id[k];
    step();
  endtask

  // Keep requester i valid until it has been granted n_i times.
  task automatic run_both(input int k, input int n0, input int n1,
                          input logic [15:0] c0, input logic [15:0] c1);
    int g0, g1, t, h0;
    cmd0[k] = c0; cmd1[k] = c1;
    g0 = 0; g1 = 0; t = 0; h0 = n_hs[k];
    rsp_ready[k] = 1'b1;
    req_valid[k] = {n1 > 0, n0 > 0};
    while ((n_hs[k] < h0 + n0 + n1) && t < 200) begin
      @(negedge clk);
      if (req_ready[k][0]) g0++;
      if (req_ready[k][1]) g1++;
      step();
      req_valid[k] = {g1 < n1, g0 < n0};
      t++;
    end
    chk("both_timeout", 32'(n_hs[k] - h0), 32'(n0 + n1));
  endtask

  logic [5:0]  d;
  bit          e, id;
  logic [1:0]  acc;
  logic [15:0] rc;
  int          t;

  initial begin
    for (int k = 0; k < 2; k++) begin
      rst_n[k] = 1'b0; req_valid[k] = 2'b00; cmd0[k] = '0; cmd1[k] = '0;
      rsp_ready[k] = 1'b1; exp_v[k] = 1'b0; n_hs[k] = 0; id_hist[k] = '0; last_data[k] = '0;
    end
    repeat (3) step();
    rst_n[0] = 1'b1; rst_n[1] = 1'b1;

    // Single requester: 3 + 2 + cin.
    do_cmd(0, 0, mk(0, 0, 0, 0, 0, 0, 1'b1, 3'd2, 3'd2, 3'd3), 0, 1'b0, d, e, id);
    chk("t2_data", 32'(d), 32'd6);
    chk("t2_id", 32'(id), 32'd0);
    chk("t2_err", 32'(e), 32'd0);

    // Reset while the ALSU is computing: the command is dropped.
    cmd0[0] = mk(0, 0, 0, 0, 0, 0, 0, 3'd3, 3'd1, 3'd3);
    req_valid[0][0] = 1'b1;
    t = 0;
    do begin @(negedge clk); t++; end while (!req_ready[0][0] && t < 50);
    chk("t1_acc", 32'(req_ready[0][0]), 32'd1);
    step();
    req_valid[0][0] = 1'b0;
    @(posedge clk);
    #2 rst_n[0] = 1'b0;
    @(negedge clk);
    chk("t1_busy", 32'(busy[0]), 32'd0);
    chk("t1_rspv", 32'(rsp_valid[0]), 32'd0);
    chk("t1_ctl", 32'(alsu_ctl[0]), 32'(IDLE_PAT));
    step();
    rst_n[0] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("t1_no_rsp", 32'(rsp_valid[0]), 32'd0);
    end
    step();

    // Round robin with both requesters continuously valid: -2 * 3.
    rc = mk(0, 0, 0, 0, 0, 0, 0, 3'd3, 3'd3, 3'b110);
    run_both(0, 2, 2, rc, rc);
    chk("t3_ids", 32'(id_hist[0][3:0]), 32'b0101);
    chk("t3_data", 32'(last_data[0]), 32'h3A);

    // Fixed priority: req0 wins both ties, then req1's held command (-1 & 3).
    run_both(1, 2, 1, mk(0, 0, 0, 0, 0, 0, 0, 3'd2, 3'd1, 3'd1),
                      mk(0, 0, 0, 0, 0, 0, 0, 3'd0, 3'd3, 3'b111));
    chk("t4_ids", 32'(id_hist[1][2:0]), 32'b001);
    chk("t4_data", 32'(last_data[1]), 32'd3);

    // Shift and rotate start from a zeroed ALSU.
    do_cmd(0, 0, mk(1'b1, 1'b1, 0, 0, 0, 0, 0, 3'd4, 3'd0, 3'd0), 0, 1'b0, d, e, id);
    chk("t5_shift", 32'(d), 32'b000001);
    do_cmd(0, 0, mk(0, 0, 0, 0, 0, 0, 0, 3'd3, 3'd1, 3'd3), 0, 1'b0, d, e, id);
    chk("t5_mul", 32'(d), 32'd3);
    do_cmd(0, 0, mk(0, 0, 0, 0, 0, 0, 0, 3'd5, 3'd0, 3'd0), 0, 1'b0, d, e, id);
    chk("t5_rot", 32'(d), 32'd0);

    // Invalid opcode, bypassed invalid command under back-pressure with a pending requester.
    do_cmd(0, 0, mk(0, 0, 0, 0, 0, 0, 0, 3'd6, 3'd1, 3'd1), 0, 1'b0, d, e, id);
    chk("t6_err", 32'(e), 32'd1);
    chk("t6_err_data", 32'(d), 32'd0);
    cmd1[0] = mk(0, 0, 0, 0, 0, 0, 0, 3'd2, 3'd1, 3'd1);
    do_cmd(0, 0, mk(0, 0, 1'b1, 0, 0, 1'b1, 0, 3'd2, 3'b111, 3'd0), 5, 1'b1, d, e, id);
    chk("t6_byp_err", 32'(e), 32'd0);
    chk("t6_byp_data", 32'(d), 32'h3F);
    do_cmd(0, 1, cmd1[0], 0, 1'b0, d, e, id);
    chk("t6_pend_id", 32'(id), 32'd1);
    chk("t6_pend_data", 32'(d), 32'd2);

    // Randomized traffic with random back-pressure on both instances.
    for (int k = 0; k < 2; k++) begin
      req_valid[k] = 2'b00;
      for (int i = 0; i < 400; i++) begin
        @(negedge clk);
        acc = req_ready[k];
        step();
        for (int r = 0; r < 2; r++) begin
          if (acc[r]) req_valid[k][r] = 1'b0;
          if (!req_valid[k][r]) begin
            rc = 16'($urandom);
            if (r == 0) cmd0[k] = rc; else cmd1[k] = rc;
            if (!acc[r] && $urandom_range(2) == 0) req_valid[k][r] = 1'b1;
          end
        end
        rsp_ready[k] = 1'($urandom_range(1));
      end
      t = 0;
      while ((req_valid[k] != 2'b00 || exp_v[k]) && t < 200) begin
        @(negedge clk);
        acc = req_ready[k];
        step();
        req_valid[k] = req_valid[k] & ~acc;
        rsp_ready[k] = 1'b1;
        t++;
      end
      chk("drain_timeout", 32'(req_valid[k] != 2'b00 || exp_v[k]), 32'd0);
    end

    repeat (3) step();
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
